// File: rtl/bsg_acm_pkg.sv
// Shared types and helpers for the bsg_acm cell-array sequencer.
// State encodings are fixed so netlists and waveforms stay comparable with the legacy design.
package bsg_acm_pkg;

  localparam logic [1:0] state_load_c  = 2'd0;
  localparam logic [1:0] state_run_c   = 2'd1;
  localparam logic [1:0] state_drain_c = 2'd2;

  typedef enum logic [1:0] {
    eLOAD  = state_load_c,
    eRUN   = state_run_c,
    eDRAIN = state_drain_c
  } state_e;

  // Flat bit index of cell (r,c) in a row-major grid that is w cells wide.
  function automatic int unsigned cell_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned w);
    return r * w + c;
  endfunction

endpackage

// File: rtl/bsg_acm_row_sel.sv
// height_p-to-1 row multiplexer: returns the width_p-bit row of cells_i selected by row_i.
module bsg_acm_row_sel
  import bsg_acm_pkg::*;
#(
  parameter int width_p  = 8,
  parameter int height_p = 8,
  parameter int row_w_p  = 3
) (
  input  logic [height_p*width_p-1:0] cells_i,
  input  logic [row_w_p-1:0]          row_i,
  output logic [width_p-1:0]          data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned r = 0; r < height_p; r++) begin
      if (row_i == row_w_p'(r)) begin
        data_o = cells_i[cell_idx(r, 0, width_p) +: width_p];
      end
    end
  end

endmodule

// File: rtl/bsg_acm_grid_ctrl.sv
// Load / run / drain sequencer for the bsg_acm_cell pixel array.
// Update strobes are combinational so the cells capture a row on the same edge it is accepted.
module bsg_acm_grid_ctrl
  import bsg_acm_pkg::*;
#(
  parameter int width_p      = 8,
  parameter int height_p     = 8,
  parameter int iter_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  input  logic [iter_width_p-1:0]      iters_i,
  output logic                         ready_o,
  output logic [height_p*width_p-1:0]  update_o,
  output logic [height_p*width_p-1:0]  update_val_o,
  output logic                         en_o,
  input  logic [height_p*width_p-1:0]  cells_i,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic                         busy_o
);

  localparam int row_w_lp = (height_p > 1) ? $clog2(height_p) : 1;

  state_e                  state_r;
  logic [row_w_lp-1:0]     row_cnt_r;
  logic [iter_width_p-1:0] iter_cnt_r;

  logic                    in_load, in_run, in_drain;
  logic                    accept, last_row, iter_zero;
  logic [width_p-1:0]      row_data;

  // Every output is forced low while reset is held, whatever the state register says.
  assign in_load  = reset_n_i && (state_r == eLOAD);
  assign in_run   = reset_n_i && (state_r == eRUN);
  assign in_drain = reset_n_i && (state_r == eDRAIN);

  assign accept   = in_load && v_i;
  assign last_row = (row_cnt_r == row_w_lp'(height_p - 1));

  // On a row-0 accept the count has not been latched yet, so look at iters_i directly.
  assign iter_zero = (row_cnt_r == '0) ? (iters_i == '0) : (iter_cnt_r == '0);

  assign ready_o = in_load;
  assign en_o    = in_run;
  assign v_o     = in_drain;
  assign busy_o  = in_run || in_drain;
  assign data_o  = in_drain ? row_data : '0;

  bsg_acm_row_sel #(
    .width_p  (width_p),
    .height_p (height_p),
    .row_w_p  (row_w_lp)
  ) row_sel (
    .cells_i (cells_i),
    .row_i   (row_cnt_r),
    .data_o  (row_data)
  );

  always_comb begin
    update_o     = '0;
    update_val_o = '0;
    if (accept) begin
      for (int unsigned r = 0; r < height_p; r++) begin
        if (row_cnt_r == row_w_lp'(r)) begin
          update_o[cell_idx(r, 0, width_p) +: width_p]     = '1;
          update_val_o[cell_idx(r, 0, width_p) +: width_p] = data_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= eLOAD;
      row_cnt_r  <= '0;
      iter_cnt_r <= '0;
    end else begin
      case (state_r)
        eLOAD: begin
          if (v_i) begin
            if (row_cnt_r == '0) begin
              iter_cnt_r <= iters_i;
            end
            if (last_row) begin
              row_cnt_r <= '0;
              state_r   <= iter_zero ? eDRAIN : eRUN;
            end else begin
              row_cnt_r <= row_cnt_r + 1'b1;
            end
          end
        end
        eRUN: begin
          iter_cnt_r <= iter_cnt_r - 1'b1;
          if (iter_cnt_r == iter_width_p'(1)) begin
            state_r <= eDRAIN;
          end
        end
        eDRAIN: begin
          if (yumi_i) begin
            if (last_row) begin
              row_cnt_r <= '0;
              state_r   <= eLOAD;
            end else begin
              row_cnt_r <= row_cnt_r + 1'b1;
            end
          end
        end
        default: begin
          state_r   <= eLOAD;
          row_cnt_r <= '0;
        end
      endcase
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule
